// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart transmitter between
// NUM_REQ requesters, with packet lock and a 2-flop tx_rdy synchroniser.
// Optional macro UART_ARB_LOCK_TIMEOUT_EN: drops a held lock after
// LOCK_TIMEOUT idle cycles in HOLD.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   uart_tx_en,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_rdy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_CAPTURE,
    ST_SEND,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_lock;
  logic                 r_tx_en;
  logic [7:0]           r_tx_data;
  logic                 r_rdy_m;
  logic                 r_rdy_s;

  logic                 w_pick_vld;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [IDX_W:0]       w_rot;
  logic                 w_own_req;
  logic                 w_own_last;
  logic [7:0]           w_own_data;
  logic [IDX_W-1:0]     w_ptr_next;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam logic [15:0] LOCK_TO_W = 16'(LOCK_TIMEOUT);
  logic [15:0]          r_to_cnt;
`else
  logic                 w_unused_lock_to;
  assign w_unused_lock_to = (LOCK_TIMEOUT == 0);
`endif

  // Two-flop synchroniser for the tx_clk-domain ready; idles high.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_m <= 1'b1;
      r_rdy_s <= 1'b1;
    end else begin
      r_rdy_m <= uart_tx_rdy;
      r_rdy_s <= r_rdy_m;
    end
  end

  // Round-robin pick: scan downward so the closest requester at/after r_ptr wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_pick_oh  = '0;
    w_rot      = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_rot = {1'b0, r_ptr} + (IDX_W+1)'(k - 1);
      if (w_rot >= NUM_REQ_W) w_rot = w_rot - NUM_REQ_W;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (IDX_W'(i) == w_rot[IDX_W-1:0])) begin
          w_pick_vld   = 1'b1;
          w_pick_idx   = IDX_W'(i);
          w_pick_oh    = '0;
          w_pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // Select the current owner's request, last flag and byte.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == r_owner) begin
        w_own_req  = req[i];
        w_own_last = req_last[i];
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  // Pointer advance past the owner, wrapping at NUM_REQ.
  always_comb begin
    if (r_owner == LAST_IDX) w_ptr_next = '0;
    else                     w_ptr_next = r_owner + 1'b1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ack     <= '0;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          r_grant <= '0;
          if (|req) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_ack   <= w_pick_oh;
            r_state <= ST_CAPTURE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          r_tx_data <= w_own_data;
          r_lock    <= !w_own_last;
          r_tx_en   <= 1'b1;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          if (!r_rdy_s) begin
            r_tx_en <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_rdy_s) begin
            if (r_lock) begin
              r_state  <= ST_HOLD;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
              r_to_cnt <= '0;
`endif
            end else begin
              r_ptr   <= w_ptr_next;
              r_grant <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (w_own_req) begin
            r_ack   <= r_grant;
            r_state <= ST_CAPTURE;
          end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
          else if (r_to_cnt >= LOCK_TO_W) begin
            r_lock  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack          = r_ack;
  assign grant        = r_grant;
  assign busy         = (r_state != ST_IDLE);
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: requester queues, a uart model and a
// scoreboard of expected {grant, byte} pairs in transmit order.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;

  logic              clk_50m;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              uart_tx_en;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_rdy;

  uart_tx_arb #(
    .NUM_REQ(NREQ),
    .IDX_W(3),
    .LOCK_TIMEOUT(65535)
  ) dut (
    .clk_50m(clk_50m),
    .rst_n(rst_n),
    .req(req),
    .req_last(req_last),
    .req_data(req_data),
    .ack(ack),
    .grant(grant),
    .busy(busy),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_rdy(uart_tx_rdy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_frames = 0;
  int n_done = 0;
  int n_acks = 0;
  int uart_start_dly = 3;
  int uart_frame_len = 20;

  logic [11:0] exp_q[$];
  logic [8:0]  rq_mem[NREQ][16];
  int          rq_hd[NREQ];
  int          rq_tl[NREQ];
  logic [NREQ-1:0] seen_ack;

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  function automatic void drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (rq_hd[i] != rq_tl[i]) begin
        req[i]            = 1'b1;
        req_last[i]       = rq_mem[i][rq_hd[i] % 16][8];
        req_data[8*i +: 8] = rq_mem[i][rq_hd[i] % 16][7:0];
      end else begin
        req[i]            = 1'b0;
        req_last[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  endfunction

  function automatic bit rq_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq_hd[i] != rq_tl[i]) e = 1'b0;
    return e;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    rq_mem[r][rq_tl[r] % 16] = {l, d};
    rq_tl[r] = rq_tl[r] + 1;
    drive_reqs();
  endtask

  function automatic void expect_frame(input logic [3:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endfunction

  function automatic void flush_reqs();
    for (int i = 0; i < NREQ; i++) rq_hd[i] = rq_tl[i];
    drive_reqs();
  endfunction

  // Requesters: advance one cycle after seeing ack, and check ack legality.
  initial begin
    seen_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_hd[i] = 0;
      rq_tl[i] = 0;
    end
    drive_reqs();
    forever begin
      @(posedge clk_50m); #1;
      for (int i = 0; i < NREQ; i++) if (seen_ack[i] && rq_hd[i] != rq_tl[i]) rq_hd[i] = rq_hd[i] + 1;
      if (ack !== '0) begin
        n_acks++;
        n_chk++;
        if (((ack & ~req) !== '0) || !$onehot(ack) || (ack !== grant)) begin
          n_fail++;
          $display("FAIL ack_legal: ack=%b req=%b grant=%b (want one-hot, requested, equal to grant)", ack, req, grant);
        end
      end
      seen_ack = ack;
      drive_reqs();
    end
  end

  // Uart model: starts a frame after uart_start_dly samples of tx_en, scoreboard check at start.
  initial begin : uart_model
    int en_cnt;
    logic [11:0] e;
    en_cnt = 0;
    uart_tx_rdy = 1'b1;
    forever begin
      @(posedge clk_50m); #1;
      if (uart_tx_en && rst_n) begin
        en_cnt++;
        if (en_cnt >= uart_start_dly) begin
          n_frames++;
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got grant=%b data=%h, want no frame", grant, uart_tx_data);
          end else begin
            e = exp_q.pop_front();
            if ({grant, uart_tx_data} !== e) begin
              n_fail++;
              $display("FAIL frame: got grant=%b data=%h, want grant=%b data=%h", grant, uart_tx_data, e[11:8], e[7:0]);
            end
          end
          uart_tx_rdy = 1'b0;
          repeat (uart_frame_len) @(posedge clk_50m);
          #1;
          uart_tx_rdy = 1'b1;
          n_done++;
          en_cnt = 0;
        end
      end else begin
        en_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk_50m); #2;
      if (exp_q.size() == 0 && !busy && rq_empty() && uart_tx_rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_50m); #3;
    rst_n = 1'b0;
    flush_reqs();
    exp_q.delete();
    repeat (2) @(posedge clk_50m);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_50m);
    #2;
    n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", uart_tx_en); end
    n_chk++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); end
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_50m);
  endtask

  task automatic test_single();
    bit ok;
    @(posedge clk_50m); #3;
    push_byte(0, 8'h55, 1'b1);
    expect_frame(4'b0001, 8'h55);
    @(posedge clk_50m); #2;
    n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_early: got %b want 0000", ack); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    @(posedge clk_50m); #2;
    n_chk++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack_lat: got %b want 0001", ack); end
    @(posedge clk_50m); #2;
    n_chk++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL single_tx_en: got %b want 1", uart_tx_en); end
    n_chk++; if (uart_tx_data !== 8'h55) begin n_fail++; $display("FAIL single_tx_data: got %h want 55", uart_tx_data); end
    wait_done(200, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", ok); end
    n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_idle: got %b want 0000", grant); end
    // Pointer now 1: requester 1 beats requester 0.
    @(posedge clk_50m); #3;
    push_byte(0, 8'h77, 1'b1);
    push_byte(1, 8'h66, 1'b1);
    expect_frame(4'b0010, 8'h66);
    expect_frame(4'b0001, 8'h77);
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_ptr_done: got %b want 1", ok); end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    // Pointer 0: 0 then 2; pointer ends at 3.
    @(posedge clk_50m); #3;
    push_byte(0, 8'hA1, 1'b1);
    push_byte(2, 8'hC3, 1'b1);
    expect_frame(4'b0001, 8'hA1);
    expect_frame(4'b0100, 8'hC3);
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_r1_done: got %b want 1", ok); end
    // Pointer 3: 3 then wrap to 1; pointer ends at 2.
    @(posedge clk_50m); #3;
    push_byte(1, 8'hB2, 1'b1);
    push_byte(3, 8'hD4, 1'b1);
    expect_frame(4'b1000, 8'hD4);
    expect_frame(4'b0010, 8'hB2);
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_r2_done: got %b want 1", ok); end
    // Pointer 2: requester 2 wins over 0.
    @(posedge clk_50m); #3;
    push_byte(0, 8'hA1, 1'b1);
    push_byte(2, 8'hC3, 1'b1);
    expect_frame(4'b0100, 8'hC3);
    expect_frame(4'b0001, 8'hA1);
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_r3_done: got %b want 1", ok); end
  endtask

  task automatic test_packet_lock();
    bit ok;
    int bad;
    int f0;
    int d0;
    apply_reset();
    f0 = n_frames;
    d0 = n_done;
    bad = 0;
    @(posedge clk_50m); #3;
    push_byte(1, 8'h10, 1'b0);
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    expect_frame(4'b0010, 8'h10);
    expect_frame(4'b0010, 8'h11);
    expect_frame(4'b0010, 8'h12);
    expect_frame(4'b1000, 8'h33);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk_50m); #2;
      if (n_done - d0 >= 3) break;
      if (n_frames - f0 >= 1 && grant !== 4'b0010) bad++;
    end
    n_chk++; if (n_done - d0 !== 3) begin n_fail++; $display("FAIL lock_frames: got %0d want 3", n_done - d0); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL lock_grant_held: got %0d bad cycles want 0", bad); end
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lock_done: got %b want 1", ok); end
  endtask

  task automatic test_slow_uart();
    bit ok;
    bit seen;
    int hi;
    int bad;
    int f0;
    int a0;
    uart_start_dly = 500;
    f0 = n_frames;
    a0 = n_acks;
    seen = 1'b0;
    hi = 0;
    bad = 0;
    @(posedge clk_50m); #3;
    push_byte(2, 8'h5A, 1'b1);
    expect_frame(4'b0100, 8'h5A);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_50m); #2;
      if (uart_tx_en) begin seen = 1'b1; break; end
    end
    n_chk++; if (seen !== 1'b1) begin n_fail++; $display("FAIL slow_tx_en_rise: got %b want 1", seen); end
    while (uart_tx_en && hi < 700) begin
      if (uart_tx_data !== 8'h5A || grant !== 4'b0100) bad++;
      hi++;
      @(posedge clk_50m); #2;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL slow_data_stable: got %0d bad cycles want 0", bad); end
    // 500 samples before the uart starts, plus two sync stages of reaction.
    n_chk++; if (hi !== 502) begin n_fail++; $display("FAIL slow_tx_en_len: got %0d want 502", hi); end
    wait_done(200, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL slow_done: got %b want 1", ok); end
    n_chk++; if (n_frames - f0 !== 1) begin n_fail++; $display("FAIL slow_frames: got %0d want 1", n_frames - f0); end
    n_chk++; if (n_acks - a0 !== 1) begin n_fail++; $display("FAIL slow_acks: got %0d want 1", n_acks - a0); end
    uart_start_dly = 3;
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    bit seen;
    uart_start_dly = 50;
    seen = 1'b0;
    @(posedge clk_50m); #3;
    push_byte(0, 8'h99, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_50m); #2;
      if (uart_tx_en) begin seen = 1'b1; break; end
    end
    n_chk++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx_en_rise: got %b want 1", seen); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx_en: got %b want 0", uart_tx_en); end
    n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_grant: got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0000", ack); end
    n_chk++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tx_data: got %h want 00", uart_tx_data); end
    flush_reqs();
    exp_q.delete();
    repeat (2) @(posedge clk_50m);
    #5 rst_n = 1'b1;
    uart_start_dly = 3;
    // Pointer back at 0: requester 1 before requester 3.
    @(posedge clk_50m); #3;
    push_byte(3, 8'hE3, 1'b1);
    push_byte(1, 8'hE1, 1'b1);
    expect_frame(4'b0010, 8'hE1);
    expect_frame(4'b1000, 8'hE3);
    wait_done(400, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after_done: got %b want 1", ok); end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_slow_uart();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
